// File: rtl/riscv_pkg.sv
// Shared RV32 constants: load/store func3 encodings, memory-stage FSM states and default width.
package riscv_pkg;

    localparam int unsigned XLEN_DEF = 32;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic {
        IDLE,
        BUSY
    } mem_state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// EX/MEM inputs, data-memory port and MEM/WB outputs of the memory stage.
interface mem_access_stage_if #(
    parameter int unsigned XLEN = riscv_pkg::XLEN_DEF
);
    logic            ex_valid;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [2:0]      func3;
    logic [4:0]      rd_mem;
    logic            mem_read_mem;
    logic            mem_write_mem;
    logic            wb_enable_mem;
    logic            ld_mem;
    logic            stall_ex;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_wstrb;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;
    logic            wb_valid;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      wb_rd;
    logic            wb_enable_wb;
    logic            ld_wb;
    logic            misalign_err;
    logic            bus_err;

    modport master (
        input  ex_valid, alu_result, store_data, func3, rd_mem, mem_read_mem, mem_write_mem,
               wb_enable_mem, ld_mem, dmem_ack, dmem_rdata,
        output stall_ex, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
               wb_valid, wb_data, wb_rd, wb_enable_wb, ld_wb, misalign_err, bus_err
    );

    modport slave (
        output ex_valid, alu_result, store_data, func3, rd_mem, mem_read_mem, mem_write_mem,
               wb_enable_mem, ld_mem, dmem_ack, dmem_rdata,
        input  stall_ex, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
               wb_valid, wb_data, wb_rd, wb_enable_wb, ld_wb, misalign_err, bus_err
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores, load extract/extend and misalignment detection.
module lsu_lane_align (
    input  logic [2:0]  func3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    always_comb begin
        byte_sel    = rdata_i[7:0];
        half_sel    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sext        = ~func3_i[2];
        wdata_o     = store_data_i;
        wstrb_o     = '1;
        load_data_o = rdata_i;
        misalign_o  = 1'b0;

        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase

        // func3[1:0] gives access width; 2'b11 (and the undefined 110/111) fall into word
        case (func3_i[1:0])
            2'b00: begin
                wdata_o     = {4{store_data_i[7:0]}};
                wstrb_o     = 4'b0001 << addr_lo_i;
                load_data_o = {{24{sext & byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                wdata_o     = {2{store_data_i[15:0]}};
                wstrb_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                load_data_o = {{16{sext & half_sel[15]}}, half_sel};
                misalign_o  = addr_lo_i[0];
            end
            default: begin
                misalign_o  = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: latches EX/MEM, runs loads/stores over a req/ack port with timeout, drives MEM/WB.
module mem_access_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEF,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst,
    mem_access_stage_if.master bus
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    mem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      func3_q, func3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [4:0]      rd_q, rd_d;
    logic            wben_q, wben_d;
    logic            ld_q, ld_d;
    logic            store_q, store_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            wb_valid_q, wb_valid_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            wb_en_q, wb_en_d;
    logic            ld_wb_q, ld_wb_d;
    logic            mis_q, mis_d;
    logic            berr_q, berr_d;

    logic [2:0]  al_func3;
    logic [1:0]  al_addr;
    logic [31:0] al_wdata, al_load;
    logic [3:0]  al_wstrb;
    logic        al_mis;
    logic        is_mem;

    // Aligner sees the incoming op in IDLE and the latched load while BUSY
    assign al_func3 = (state_q == BUSY) ? func3_q : bus.func3;
    assign al_addr  = (state_q == BUSY) ? addr_lo_q : bus.alu_result[1:0];
    assign is_mem   = bus.mem_read_mem | bus.mem_write_mem;

    lsu_lane_align u_align (
        .func3_i      (al_func3),
        .addr_lo_i    (al_addr),
        .store_data_i (bus.store_data),
        .rdata_i      (bus.dmem_rdata),
        .wdata_o      (al_wdata),
        .wstrb_o      (al_wstrb),
        .load_data_o  (al_load),
        .misalign_o   (al_mis)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        func3_d    = func3_q;
        addr_lo_d  = addr_lo_q;
        rd_d       = rd_q;
        wben_d     = wben_q;
        ld_d       = ld_q;
        store_d    = store_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_en_d    = wb_en_q;
        ld_wb_d    = ld_wb_q;
        mis_d      = 1'b0;
        berr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.ex_valid) begin
                    func3_d   = bus.func3;
                    addr_lo_d = bus.alu_result[1:0];
                    rd_d      = bus.rd_mem;
                    wben_d    = bus.wb_enable_mem;
                    ld_d      = bus.ld_mem;
                    store_d   = bus.mem_write_mem;
                    if (!is_mem || al_mis) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = bus.alu_result;
                        wb_rd_d    = bus.rd_mem;
                        wb_en_d    = bus.wb_enable_mem & ~is_mem;
                        ld_wb_d    = bus.ld_mem;
                        mis_d      = is_mem;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = bus.mem_write_mem;
                        addr_d  = {bus.alu_result[XLEN-1:2], 2'b00};
                        wdata_d = bus.mem_write_mem ? al_wdata : '0;
                        wstrb_d = bus.mem_write_mem ? al_wstrb : '0;
                    end
                end
            end
            BUSY: begin
                if (bus.dmem_ack || cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wstrb_d    = '0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    ld_wb_d    = ld_q;
                    berr_d     = ~bus.dmem_ack;
                    wb_en_d    = bus.dmem_ack & ~store_q & wben_q;
                    wb_data_d  = (bus.dmem_ack && !store_q) ? al_load
                                                            : {addr_q[XLEN-1:2], addr_lo_q};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            func3_q    <= '0;
            addr_lo_q  <= '0;
            rd_q       <= '0;
            wben_q     <= 1'b0;
            ld_q       <= 1'b0;
            store_q    <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_en_q    <= 1'b0;
            ld_wb_q    <= 1'b0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            func3_q    <= func3_d;
            addr_lo_q  <= addr_lo_d;
            rd_q       <= rd_d;
            wben_q     <= wben_d;
            ld_q       <= ld_d;
            store_q    <= store_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_en_q    <= wb_en_d;
            ld_wb_q    <= ld_wb_d;
            mis_q      <= mis_d;
            berr_q     <= berr_d;
        end
    end

    assign bus.stall_ex     = (state_q == BUSY);
    assign bus.dmem_req     = req_q;
    assign bus.dmem_we      = we_q;
    assign bus.dmem_addr    = addr_q;
    assign bus.dmem_wdata   = wdata_q;
    assign bus.dmem_wstrb   = wstrb_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_enable_wb = wb_en_q;
    assign bus.ld_wb        = ld_wb_q;
    assign bus.misalign_err = mis_q;
    assign bus.bus_err      = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Table-driven bench for mem_access_stage with a writeback scoreboard and reset/timeout sequences.
module tb_mem_access_stage;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_access_stage_if bus ();

    mem_access_stage #(.XLEN(32), .ACK_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        rd_op;
        logic        wr_op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          ack;      // BUSY cycle index carrying ack; -1 = never
        logic        wben;
        logic        ld;
        logic [31:0] edata;
        logic        een;
        logic        emis;
        logic        eberr;
        logic        full;     // wb_data/ld_wb are defined for this op
        logic [3:0]  estrb;
        logic [31:0] ewdata;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        en;
        logic        ld;
        logic        mis;
        logic        berr;
        logic        full;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [2:0] f3, input logic r, input logic w,
                                input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdat,
                                input int ack, input logic wben, input logic ld,
                                input logic [31:0] edata, input logic een, input logic emis,
                                input logic eberr, input logic full, input logic [3:0] estrb,
                                input logic [31:0] ewd);
        vec_t v;
        v.name = nm; v.f3 = f3; v.rd_op = r; v.wr_op = w; v.addr = addr; v.sdata = sd;
        v.rdata = rdat; v.ack = ack; v.wben = wben; v.ld = ld; v.edata = edata; v.een = een;
        v.emis = emis; v.eberr = eberr; v.full = full; v.estrb = estrb; v.ewdata = ewd;
        return v;
    endfunction

    // Writeback monitor: every wb_valid pulse retires the oldest expected entry
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wb_valid) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got wb_valid=1 expected no retirement at %0t", $time);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk({e.name, ".wb_rd"}, 32'(bus.wb_rd), 32'(e.rd));
                    chk({e.name, ".wb_en"}, 32'(bus.wb_enable_wb), 32'(e.en));
                    chk({e.name, ".mis"}, 32'(bus.misalign_err), 32'(e.mis));
                    chk({e.name, ".berr"}, 32'(bus.bus_err), 32'(e.berr));
                    if (e.full) begin
                        chk({e.name, ".wb_data"}, bus.wb_data, e.data);
                        chk({e.name, ".ld_wb"}, 32'(bus.ld_wb), 32'(e.ld));
                    end
                end
            end else begin
                chk("stray_err", {30'd0, bus.misalign_err, bus.bus_err}, 32'd0);
            end
        end
    end

    task automatic run_vec(input vec_t v, input logic [4:0] rd);
        exp_t e;
        int   busy;
        int   exp_busy;
        logic access;
        bus.ex_valid      = 1'b1;
        bus.alu_result    = v.addr;
        bus.store_data    = v.sdata;
        bus.func3         = v.f3;
        bus.rd_mem        = rd;
        bus.mem_read_mem  = v.rd_op;
        bus.mem_write_mem = v.wr_op;
        bus.wb_enable_mem = v.wben;
        bus.ld_mem        = v.ld;
        e.name = v.name; e.data = v.edata; e.rd = rd; e.en = v.een; e.ld = v.ld;
        e.mis = v.emis; e.berr = v.eberr; e.full = v.full;
        sbq.push_back(e);
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        access = (v.rd_op || v.wr_op) && !v.emis;
        if (!access) begin
            chk({v.name, ".no_req"}, 32'(bus.dmem_req), 32'd0);
            chk({v.name, ".no_stall"}, 32'(bus.stall_ex), 32'd0);
            @(posedge clk); #1;
        end else begin
            chk({v.name, ".addr"}, bus.dmem_addr, {v.addr[31:2], 2'b00});
            chk({v.name, ".we"}, 32'(bus.dmem_we), 32'(v.wr_op));
            chk({v.name, ".wstrb"}, 32'(bus.dmem_wstrb), 32'(v.estrb));
            if (v.wr_op) chk({v.name, ".wdata"}, bus.dmem_wdata, v.ewdata);
            busy = 0;
            while (bus.stall_ex && busy < 64) begin
                chk({v.name, ".req_held"}, 32'(bus.dmem_req), 32'd1);
                if (busy == v.ack) begin
                    bus.dmem_ack   = 1'b1;
                    bus.dmem_rdata = v.rdata;
                end
                @(posedge clk); #1;
                bus.dmem_ack = 1'b0;
                busy++;
            end
            exp_busy = (v.ack < 0) ? 16 : v.ack + 1;
            chk({v.name, ".busy_cycles"}, 32'(busy), 32'(exp_busy));
            chk({v.name, ".req_drop"}, 32'(bus.dmem_req), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.ex_valid = 1'b0; bus.alu_result = '0; bus.store_data = '0; bus.func3 = '0;
        bus.rd_mem = '0; bus.mem_read_mem = 1'b0; bus.mem_write_mem = 1'b0;
        bus.wb_enable_mem = 1'b0; bus.ld_mem = 1'b0; bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.stall", 32'(bus.stall_ex), 32'd0);
        chk("rst.req", 32'(bus.dmem_req), 32'd0);
        chk("rst.wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst.wb_data", bus.wb_data, 32'd0);
        chk("rst.errs", {30'd0, bus.misalign_err, bus.bus_err}, 32'd0);
        rst = 1'b0;

        //             name     f3      r     w     addr          sdata         rdata         ack wbe   ld    edata         een   emis  eberr full  strb     wdata
        tbl.push_back(mk("alu",  3'b000, 1'b0, 1'b0, 32'h1234_5678, 32'h0,        32'h0,        -1, 1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0));
        tbl.push_back(mk("lb",   3'b000, 1'b1, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 3, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0));
        tbl.push_back(mk("lbu",  3'b100, 1'b1, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 3, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0));
        tbl.push_back(mk("sh",   3'b001, 1'b0, 1'b1, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0,        1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, 32'hBEEF_BEEF));
        tbl.push_back(mk("lw_mis",3'b010,1'b1, 1'b0, 32'h0000_0301, 32'h0,        32'h0,        -1, 1'b1, 1'b1, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0));
        tbl.push_back(mk("sh_mis",3'b001,1'b0, 1'b1, 32'h0000_0301, 32'h0,        32'h0,        -1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0));
        tbl.push_back(mk("lb301",3'b000, 1'b1, 1'b0, 32'h0000_0301, 32'h0,        32'h1234_56A5, 0, 1'b1, 1'b1, 32'h0000_0056, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0));
        tbl.push_back(mk("lh",   3'b001, 1'b1, 1'b0, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 2, 1'b1, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0));
        tbl.push_back(mk("lhu",  3'b101, 1'b1, 1'b0, 32'h0000_0100, 32'h0,        32'h8001_F00D, 0, 1'b1, 1'b1, 32'h0000_F00D, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0));
        tbl.push_back(mk("lw",   3'b010, 1'b1, 1'b0, 32'h0000_0400, 32'h0,        32'hDEAD_BEEF, 0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0));
        tbl.push_back(mk("sb",   3'b000, 1'b0, 1'b1, 32'h0000_0101, 32'h1234_56C3, 32'h0,        0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 32'hC3C3_C3C3));
        tbl.push_back(mk("sw",   3'b010, 1'b0, 1'b1, 32'h0000_0500, 32'hCAFE_F00D, 32'h0,        2, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 32'hCAFE_F00D));
        tbl.push_back(mk("tmo",  3'b010, 1'b1, 1'b0, 32'h0000_0600, 32'h0,        32'h0,        -1, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0));
        tbl.push_back(mk("ack15",3'b010, 1'b1, 1'b0, 32'h0000_0604, 32'h0,        32'h0BAD_F00D, 15, 1'b1, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0));
        tbl.push_back(mk("f3_011",3'b011,1'b1, 1'b0, 32'h0000_0700, 32'h0,        32'h1122_3344, 1, 1'b1, 1'b1, 32'h1122_3344, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0));
        tbl.push_back(mk("f3_110",3'b110,1'b1, 1'b0, 32'h0000_0704, 32'h0,        32'h5566_7788, 0, 1'b1, 1'b1, 32'h5566_7788, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0));
        tbl.push_back(mk("rdwr", 3'b010, 1'b1, 1'b1, 32'h0000_0800, 32'h0102_0304, 32'h0,        0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0102_0304));
        tbl.push_back(mk("lh_mis",3'b001,1'b1, 1'b0, 32'h0000_0103, 32'h0,        32'h0,        -1, 1'b1, 1'b1, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0));
        tbl.push_back(mk("lw_mis2",3'b010,1'b1,1'b0, 32'h0000_0302, 32'h0,        32'h0,        -1, 1'b1, 1'b1, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0));
        tbl.push_back(mk("alu2", 3'b000, 1'b0, 1'b0, 32'hFFFF_0001, 32'h0,        32'h0,        -1, 1'b0, 1'b0, 32'hFFFF_0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0));

        foreach (tbl[i]) run_vec(tbl[i], 5'(i + 1));
        repeat (2) @(posedge clk);
        #1;

        // Reset two cycles into BUSY abandons the access; a late ack must not retire anything
        bus.ex_valid = 1'b1; bus.alu_result = 32'h0000_0900; bus.func3 = 3'b010;
        bus.rd_mem = 5'd9; bus.mem_read_mem = 1'b1; bus.mem_write_mem = 1'b0;
        bus.wb_enable_mem = 1'b1; bus.ld_mem = 1'b1;
        @(posedge clk); #1;
        bus.ex_valid = 1'b0;
        chk("rstbusy.req_on", 32'(bus.dmem_req), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstbusy.req", 32'(bus.dmem_req), 32'd0);
        chk("rstbusy.stall", 32'(bus.stall_ex), 32'd0);
        chk("rstbusy.wb_en", 32'(bus.wb_enable_wb), 32'd0);
        rst = 1'b0;
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFACE_FACE;
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("late_ack.wb_valid", 32'(bus.wb_valid), 32'd0);
            chk("late_ack.stall", 32'(bus.stall_ex), 32'd0);
            @(posedge clk); #1;
        end

        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
